// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler
//
// Shares an eight-digit HEX display between up to NREQ sources. Sources are
// granted round-robin for a dwell of DWELL_CYCLES. The owner's 32-bit binary
// value is converted to packed BCD by a 32-cycle shift-add-3 (double-dabble)
// engine.
//
// Ports
//   iClk_50  system clock, rising edge
//   nRst     synchronous active-low reset
//   iReq     level request per source
//   iNum     32-bit value per source, source r at [32r+31:32r]
//   iBlink   blink request per source
//   oGrant   one-hot current owner (all-zero in ARB with no requests)
//   oBcd     eight BCD digits, digit d at [4d+3:4d]
//   oValid   oBcd holds at least one completed conversion
//   oBlink   blink enable latched from the owner
//   oOvf     last converted value exceeded 99_999_999 (oBcd saturated to 9s)
//   oBusy    high while latching or converting
//
// Build option
//   HEX_SCHED_LEADING_BLANK_EN  when defined, leading zero digits (never
//   digit 0) are written as 4'hF, the digit controllers' blank code.
module hex_display_scheduler #(
    parameter int NREQ         = 4,
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic               iClk_50,
    input  logic               nRst,
    input  logic [NREQ-1:0]    iReq,
    input  logic [32*NREQ-1:0] iNum,
    input  logic [NREQ-1:0]    iBlink,
    output logic [NREQ-1:0]    oGrant,
    output logic [31:0]        oBcd,
    output logic               oValid,
    output logic               oBlink,
    output logic               oOvf,
    output logic               oBusy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW = $clog2(DWELL_CYCLES);

    localparam logic [1:0] ST_ARB     = 2'd0;
    localparam logic [1:0] ST_LATCH   = 2'd1;
    localparam logic [1:0] ST_CONVERT = 2'd2;
    localparam logic [1:0] ST_SHOW    = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   ptr_q, ptr_d;          // last / current owner index
    logic [31:0]     bin_q, bin_d;
    logic [39:0]     acc_q, acc_d;
    logic            blink_hold_q, blink_hold_d;
    logic [4:0]      iter_q, iter_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [31:0]     bcd_q, bcd_d;
    logic            valid_q, valid_d;
    logic            blink_q, blink_d;
    logic            ovf_q, ovf_d;

    // Per-source value slices
    logic [31:0] num_arr [NREQ];
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_num
            assign num_arr[gi] = iNum[32*gi +: 32];
        end
    endgenerate

    // Round-robin search starting just after the last owner; the owner
    // itself is checked last, so it only wins again when nobody else asks.
    logic          arb_found;
    logic [PW-1:0] arb_idx;
    logic [PW-1:0] arb_cand;
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = ptr_q;
        arb_cand  = ptr_q;
        for (int i = 1; i <= NREQ; i++) begin
            arb_cand = PW'((int'(ptr_q) + i) % NREQ);
            if (!arb_found && iReq[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    // Double-dabble step: add 3 to every digit >= 5, then shift left.
    logic [39:0] acc_adj;
    logic [39:0] acc_shift;
    logic        shift_out_unused;  // top bit leaving the accumulator is always 0
    generate
        for (gi = 0; gi < 10; gi++) begin : g_add3
            assign acc_adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ?
                                        acc_q[4*gi +: 4] + 4'd3 : acc_q[4*gi +: 4];
        end
    endgenerate
    assign acc_shift        = {acc_adj[38:0], bin_q[31]};
    assign shift_out_unused = acc_adj[39];

    // Display image computed from the final shift result
    logic        ovf_now;
    logic [31:0] disp_bcd;
    assign ovf_now = |acc_shift[39:32];

`ifdef HEX_SCHED_LEADING_BLANK_EN
    logic [7:0] digit_nz;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nz
            assign digit_nz[gi] = |acc_shift[4*gi +: 4];
        end
        for (gi = 0; gi < 8; gi++) begin : g_disp
            if (gi == 0) begin : g_d0
                assign disp_bcd[3:0] = ovf_now ? 4'h9 : acc_shift[3:0];
            end else begin : g_dn
                // Blank when this digit and every digit above it is zero
                assign disp_bcd[4*gi +: 4] = ovf_now ? 4'h9 :
                                             (~|digit_nz[7:gi]) ? 4'hF :
                                             acc_shift[4*gi +: 4];
            end
        end
    endgenerate
`else
    generate
        for (gi = 0; gi < 8; gi++) begin : g_disp
            assign disp_bcd[4*gi +: 4] = ovf_now ? 4'h9 : acc_shift[4*gi +: 4];
        end
    endgenerate
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        bin_d        = bin_q;
        acc_d        = acc_q;
        blink_hold_d = blink_hold_q;
        iter_d       = iter_q;
        dwell_d      = dwell_q;
        bcd_d        = bcd_q;
        valid_d      = valid_q;
        blink_d      = blink_q;
        ovf_d        = ovf_q;
        case (state_q)
            ST_ARB: begin
                if (arb_found) begin
                    grant_d          = '0;
                    grant_d[arb_idx] = 1'b1;
                    ptr_d            = arb_idx;
                    state_d          = ST_LATCH;
                end else begin
                    grant_d = '0;
                end
            end
            ST_LATCH: begin
                bin_d        = num_arr[ptr_q];
                acc_d        = '0;
                blink_hold_d = iBlink[ptr_q];
                iter_d       = '0;
                state_d      = ST_CONVERT;
            end
            ST_CONVERT: begin
                acc_d  = acc_shift;
                bin_d  = {bin_q[30:0], 1'b0};
                iter_d = iter_q + 5'd1;
                if (iter_q == 5'd31) begin
                    state_d = ST_SHOW;
                    dwell_d = '0;
                    bcd_d   = disp_bcd;
                    ovf_d   = ovf_now;
                    valid_d = 1'b1;
                    blink_d = blink_hold_q;
                end
            end
            ST_SHOW: begin
                if (!iReq[ptr_q] || (dwell_q == DW'(DWELL_CYCLES - 1))) begin
                    state_d = ST_ARB;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge iClk_50) begin
        if (!nRst) begin
            state_q      <= ST_ARB;
            grant_q      <= '0;
            ptr_q        <= PW'(NREQ - 1);
            bin_q        <= '0;
            acc_q        <= '0;
            blink_hold_q <= 1'b0;
            iter_q       <= '0;
            dwell_q      <= '0;
            bcd_q        <= '0;
            valid_q      <= 1'b0;
            blink_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            bin_q        <= bin_d;
            acc_q        <= acc_d;
            blink_hold_q <= blink_hold_d;
            iter_q       <= iter_d;
            dwell_q      <= dwell_d;
            bcd_q        <= bcd_d;
            valid_q      <= valid_d;
            blink_q      <= blink_d;
            ovf_q        <= ovf_d;
        end
    end

    // The grant drops as soon as ARB sees no requests at all; with requests
    // pending the previous owner stays visible for the one ARB cycle.
    assign oGrant = ((state_q == ST_ARB) && (iReq == '0)) ? '0 : grant_q;
    assign oBcd   = bcd_q;
    assign oValid = valid_q;
    assign oBlink = blink_q;
    assign oOvf   = ovf_q;
    assign oBusy  = (state_q == ST_LATCH) || (state_q == ST_CONVERT);

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler with NREQ=4, DWELL_CYCLES=8.
// A grant taken at edge g loads the display at edge g+33; a full grant
// period (ARB + LATCH + 32 CONVERT + 8 SHOW) is 42 cycles.
module tb_hex_display_scheduler;

    localparam int NREQ  = 4;
    localparam int DWELL = 8;

`ifdef HEX_SCHED_LEADING_BLANK_EN
    localparam logic [31:0] E1234 = 32'hFFFF_1234;
    localparam logic [31:0] E5678 = 32'hFFFF_5678;
    localparam logic [31:0] E22   = 32'hFFFF_FF22;
    localparam logic [31:0] E33   = 32'hFFFF_FF33;
    localparam logic [31:0] E7    = 32'hFFFF_FFF7;
    localparam logic [31:0] E555  = 32'hFFFF_F555;
    localparam logic [31:0] E42   = 32'hFFFF_FF42;
    localparam logic [31:0] E0    = 32'hFFFF_FFF0;
`else
    localparam logic [31:0] E1234 = 32'h0000_1234;
    localparam logic [31:0] E5678 = 32'h0000_5678;
    localparam logic [31:0] E22   = 32'h0000_0022;
    localparam logic [31:0] E33   = 32'h0000_0033;
    localparam logic [31:0] E7    = 32'h0000_0007;
    localparam logic [31:0] E555  = 32'h0000_0555;
    localparam logic [31:0] E42   = 32'h0000_0042;
    localparam logic [31:0] E0    = 32'h0000_0000;
`endif

    logic               clk = 1'b0;
    logic               nrst;
    logic [NREQ-1:0]    req;
    logic [32*NREQ-1:0] num;
    logic [NREQ-1:0]    blink_in;
    logic [NREQ-1:0]    grant;
    logic [31:0]        bcd;
    logic               valid, blink, ovf, busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hex_display_scheduler #(
        .NREQ        (NREQ),
        .DWELL_CYCLES(DWELL)
    ) dut (
        .iClk_50(clk),
        .nRst   (nrst),
        .iReq   (req),
        .iNum   (num),
        .iBlink (blink_in),
        .oGrant (grant),
        .oBcd   (bcd),
        .oValid (valid),
        .oBlink (blink),
        .oOvf   (ovf),
        .oBusy  (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        nrst = 1'b0; req = '0; num = '0; blink_in = '0;
        tick(2);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_bcd",   bcd,         32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_blink", 32'(blink), 32'h0);
        chk("rst_ovf",   32'(ovf),   32'h0);
        chk("rst_busy",  32'(busy),  32'h0);

        // Single source 0, value 1234
        nrst = 1'b1; req = 4'b0001; num[31:0] = 32'd1234;
        tick(1);
        chk("single_grant", 32'(grant), 32'h1);
        chk("single_busy1", 32'(busy),  32'h1);
        chk("single_valid0", 32'(valid), 32'h0);
        tick(32);
        chk("single_busy_g32", 32'(busy),  32'h1);
        chk("single_valid_g32", 32'(valid), 32'h0);
        tick(1);
        chk("single_bcd",   bcd,         E1234);
        chk("single_valid", 32'(valid), 32'h1);
        chk("single_busy0", 32'(busy),  32'h0);
        chk("single_ovf",   32'(ovf),   32'h0);

        // Value change during SHOW only appears after the re-grant
        tick(2);
        num[31:0] = 32'd5678;
        tick(39);
        chk("hold_until_regrant", bcd, E1234);
        chk("regrant_grant", 32'(grant), 32'h1);
        tick(1);
        chk("regrant_bcd", bcd, E5678);
        req = '0;
        tick(1);
        chk("release_grant", 32'(grant), 32'h0);
        chk("release_busy",  32'(busy),  32'h0);
        chk("release_hold",  bcd,         E5678);

        // Round-robin over sources 0,1,3 starting after owner 0
        req = 4'b1011;
        num[31:0] = 32'd11; num[63:32] = 32'd22; num[127:96] = 32'd33;
        tick(1);
        chk("rr_grant1", 32'(grant), 32'h2);
        tick(33);
        chk("rr_bcd1", bcd, E22);
        tick(8);
        chk("rr_grant1_end", 32'(grant), 32'h2);
        tick(1);
        chk("rr_grant3", 32'(grant), 32'h8);
        chk("rr_bcd1_held", bcd, E22);
        tick(33);
        chk("rr_bcd3", bcd, E33);
        tick(8);
        chk("rr_grant3_end", 32'(grant), 32'h8);
        tick(1);
        chk("rr_grant0", 32'(grant), 32'h1);

        // Overflow, then the largest non-overflowing value
        req = 4'b0001; num[31:0] = 32'hFFFF_FFFF;
        tick(33);
        chk("ovf_flag",  32'(ovf),   32'h1);
        chk("ovf_bcd",   bcd,         32'h9999_9999);
        chk("ovf_blink", 32'(blink), 32'h0);
        num[31:0] = 32'd99_999_999;
        tick(9);
        chk("ovf_regrant", 32'(grant), 32'h1);
        chk("ovf_held",    32'(ovf),   32'h1);
        tick(33);
        chk("max_ovf", 32'(ovf), 32'h0);
        chk("max_bcd", bcd,       32'h9999_9999);
        req = '0;
        tick(1);
        chk("idle_grant", 32'(grant), 32'h0);

        // Source 2 with blink, released at SHOW cycle 3
        req = 4'b0100; blink_in = 4'b0100; num[95:64] = 32'd7;
        tick(1);
        chk("blink_grant", 32'(grant), 32'h4);
        tick(33);
        chk("blink_bcd", bcd,         E7);
        chk("blink_on",  32'(blink), 32'h1);
        tick(3);
        chk("show3_grant", 32'(grant), 32'h4);
        req = '0; blink_in = '0;
        tick(1);
        chk("early_grant", 32'(grant), 32'h0);
        chk("early_busy",  32'(busy),  32'h0);
        chk("early_bcd",   bcd,         E7);
        chk("early_blink", 32'(blink), 32'h1);

        // Reset at CONVERT iteration 10
        req = 4'b0010; num[63:32] = 32'd555;
        tick(1);
        chk("mid_grant", 32'(grant), 32'h2);
        tick(11);
        chk("mid_busy", 32'(busy), 32'h1);
        nrst = 1'b0;
        tick(1);
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_bcd",   bcd,         32'h0);
        chk("mid_rst_valid", 32'(valid), 32'h0);
        chk("mid_rst_blink", 32'(blink), 32'h0);
        chk("mid_rst_busy",  32'(busy),  32'h0);
        // Pointer is back at NREQ-1, so source 1 beats source 2
        nrst = 1'b1; req = 4'b0110; num[95:64] = 32'd888;
        tick(1);
        chk("restart_grant", 32'(grant), 32'h2);
        tick(33);
        chk("restart_bcd",   bcd,         E555);
        chk("restart_valid", 32'(valid), 32'h1);
        chk("restart_blink", 32'(blink), 32'h0);

        // Small values (leading-zero handling)
        req = 4'b0001; num[31:0] = 32'd42;
        tick(2);
        chk("v42_grant", 32'(grant), 32'h1);
        tick(33);
        chk("v42_bcd", bcd, E42);
        req = '0;
        tick(1);
        req = 4'b0001; num[31:0] = 32'd0;
        tick(1);
        chk("v0_grant", 32'(grant), 32'h1);
        tick(33);
        chk("v0_bcd",   bcd,         E0);
        chk("v0_ovf",   32'(ovf),   32'h0);
        chk("v0_valid", 32'(valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
